cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single Common Data Bus among NUM_REQ functional units. Each FU hands one
//  completed result (ROB tag + value) into a private one-entry holding buffer; each cycle
//  one buffered result wins round-robin and is broadcast on registered CDB outputs, which
//  feed the map table (t_plus set), reservation stations and ROB. Mispredict squash flushes all.
// PARAMETERS
//  NUM_REQ  4   number of requesting functional units (>=2)
//  TAG_W    5   ROB tag width; tag 0 is reserved as "no tag"
//  DATA_W   32  result value width
// PORTS
//  clock      in   1               system clock, all state on posedge
//  reset      in   1               synchronous, active-low (0 = reset)
//  squash     in   1               synchronous flush (branch mispredict)
//  req_valid  in   NUM_REQ         FU i offers a result
//  req_tag    in   NUM_REQ*TAG_W   ROB tag of FU i's result
//  req_value  in   NUM_REQ*DATA_W  result value of FU i
//  req_ready  out  NUM_REQ         buffer i can accept this cycle (combinational)
//  cdb_valid  out  1               broadcast valid (registered)
//  cdb_tag    out  TAG_W           broadcast ROB tag (registered)
//  cdb_value  out  DATA_W          broadcast value (registered)
//  cdb_src    out  NUM_REQ         one-hot winner of current broadcast (registered)
//  tag0_err   out  1               sticky: a tag-0 request was offered
// BEHAVIOUR
//  - Reset (reset==0 at posedge): buffers empty, rr_ptr=0, cdb_valid=0, cdb_tag=0,
//    cdb_value=0, cdb_src=0, tag0_err=0. req_ready=0 while reset==0.
//  - Handshake: transfer on req_valid[i] && req_ready[i] at posedge; buffer i captures
//    tag/value. req_ready[i] = !buf_valid[i] || grant[i] (same-cycle drain+refill allowed).
//    FU must hold tag/value stable while req_valid && !req_ready.
//  - Arbitration (comb. each cycle): among buf_valid, first index at or after rr_ptr
//    (mod NUM_REQ) wins. New arrivals are not eligible in their capture cycle.
//  - Broadcast: at posedge, winner's buffer -> cdb_* regs, cdb_src=onehot(winner), winner
//    buffer cleared unless refilled same edge; rr_ptr <= (winner+1) mod NUM_REQ.
//  - No winner: cdb_valid<=0, cdb_tag<=0, cdb_value<=0, cdb_src<=0, rr_ptr unchanged.
//    cdb_tag MUST be 0 whenever cdb_valid==0 (map table compares tags unqualified).
//  - Latency: accepted at edge N -> on CDB no earlier than after edge N+1; a buffered
//    entry waits at most NUM_REQ-1 broadcasts (starvation-free).
//  - Throughput: 1 broadcast/cycle; each FU sustains 1/cycle only when uncontended.
//  - Tag 0: request with req_tag==0 is accepted (ready obeyed) but discarded, never
//    buffered/broadcast; sets tag0_err (cleared only by reset).
//  - squash (reset==1): at posedge all buffers cleared, cdb_* zeroed, rr_ptr<=0;
//    req_ready=0 during squash cycle, so no capture. reset has priority over squash.
//  - Reset or squash mid-transfer: in-flight and buffered results dropped, none appear on CDB.
//  - Buffer full: req_ready[i]=0 until buffer i wins; FU stalls, no overwrite ever.
// TESTING
//  1 reset=0 2 cycles, all req_valid=1 -> req_ready=0, cdb_valid=0, cdb_tag=0, no capture.
//  2 Single FU1 tag=5 value=0xDEAD at edge N, others idle -> cdb_valid=1, tag=5,
//    value=0xDEAD, cdb_src=4'b0010 after edge N+1; idle next cycle with cdb_tag=0.
//  3 All 4 FUs request continuously, tags 1..4 -> broadcast order 1,2,3,4,1,... every
//    cycle, no gaps, each req_ready pulses once per 4 cycles after fill.
//  4 rr_ptr=2, buffers 0 and 3 valid -> FU3 wins, then FU0; rr_ptr ends at 1.
//  5 Buffers 0,1,2 full, squash=1 one cycle -> next cycle cdb_valid=0, buffers empty,
//    no tags from pre-squash requests ever broadcast; new request after is normal.
//  6 FU2 offers tag=0 -> req_ready=1, nothing on CDB, tag0_err=1 until reset.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one Common Data Bus among NUM_REQ functional units.
// Each FU deposits a completed result (ROB tag + value) into a private one-entry
// holding buffer; every cycle one buffered result wins round-robin and is
// broadcast on registered CDB outputs. A squash flushes everything in flight.
//
// Ports:
//   clock      in   system clock, all state on posedge
//   reset      in   synchronous, active-low
//   squash     in   synchronous flush (branch mispredict)
//   req_valid  in   [NUM_REQ]         FU i offers a result
//   req_tag    in   [NUM_REQ*TAG_W]   ROB tag of FU i's result (tag 0 = "no tag")
//   req_value  in   [NUM_REQ*DATA_W]  result value of FU i
//   req_ready  out  [NUM_REQ]         buffer i can accept this cycle (combinational)
//   cdb_valid  out  broadcast valid (registered)
//   cdb_tag    out  [TAG_W]  broadcast ROB tag, forced to 0 when not valid
//   cdb_value  out  [DATA_W] broadcast value (registered)
//   cdb_src    out  [NUM_REQ] one-hot winner of the current broadcast
//   tag0_err   out  sticky flag: a tag-0 request was accepted
module cdb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_value,
    output logic [NUM_REQ-1:0]        cdb_src,
    output logic                      tag0_err
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    logic [NUM_REQ-1:0]             buf_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0]  buf_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0] buf_value;
    logic [PTR_W-1:0]               rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [SUM_W-1:0]   cand;
    logic [NUM_REQ-1:0] xfer;
    logic [NUM_REQ-1:0] tag_zero;

    // Round-robin pick: first occupied buffer at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = SUM_W'(rr_ptr) + SUM_W'(k);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!win_found && buf_valid[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
        if (win_found) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

    // A draining buffer may be refilled on the same edge it broadcasts.
    assign req_ready = {NUM_REQ{reset & ~squash}} & (~buf_valid | grant);
    assign xfer      = req_valid & req_ready;

    // Tag 0 means "no tag": such results are accepted but never buffered.
    always_comb begin
        tag_zero = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            tag_zero[i] = (req_tag[i*TAG_W +: TAG_W] == '0);
        end
    end

    // Buffers, broadcast registers, round-robin pointer and error flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            buf_valid <= '0;
            buf_tag   <= '0;
            buf_value <= '0;
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
            tag0_err  <= 1'b0;
        end else if (squash) begin
            buf_valid <= '0;
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
        end else begin
            // Tag must read 0 when idle: consumers compare it unqualified.
            cdb_valid <= win_found;
            cdb_tag   <= win_found ? buf_tag[win_idx]   : '0;
            cdb_value <= win_found ? buf_value[win_idx] : '0;
            cdb_src   <= grant;
            if (win_found) begin
                rr_ptr <= next_ptr;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (xfer[i] && !tag_zero[i]) begin
                    buf_valid[i] <= 1'b1;
                    buf_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
                    buf_value[i] <= req_value[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            if (|(xfer & tag_zero)) begin
                tag0_err <= 1'b1;
            end
        end
    end

endmodule
